// File: rtl/slot_game_ctrl.sv
// Slot machine game controller: debounces the player button, debits a bet, launches the reels,
// evaluates the stopped reels, credits the payout and presents the balance as 3-digit BCD.
module slot_game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BUSY_TIMEOUT    = 16,
  parameter int START_CREDITS   = 10,
  parameter int BET             = 1,
  parameter int PAY_PAIR        = 2,
  parameter int PAY_TRIPLE      = 20,
  parameter int MAX_CREDITS     = 999
) (
  input  logic        clock_in,
  input  logic        CLR,
  input  logic        button,
  input  logic [3:0]  reel1,
  input  logic [3:0]  reel2,
  input  logic [3:0]  reel3,
  input  logic        reels_busy,
  output logic        spin_start,
  output logic [11:0] credits_bcd,
  output logic [1:0]  result,
  output logic        win,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBIT, S_LAUNCH, S_WAIT_BUSY, S_WAIT_STOP, S_EVAL, S_PAY
  } state_t;

  // Double-dabble; the balance is saturated below 1000 so three digits always suffice.
  function automatic logic [11:0] to_bcd(input logic [9:0] bin);
    logic [21:0] dd;
    dd = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (dd[13:10] > 4'd4) dd[13:10] = dd[13:10] + 4'd3;
      if (dd[17:14] > 4'd4) dd[17:14] = dd[17:14] + 4'd3;
      if (dd[21:18] > 4'd4) dd[21:18] = dd[21:18] + 4'd3;
      dd = {dd[20:0], 1'b0};
    end
    return dd[21:10];
  endfunction

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(BUSY_TIMEOUT - 1);
  localparam logic [9:0]    START_C    = 10'(START_CREDITS);
  localparam logic [9:0]    BET_C      = 10'(BET);
  localparam logic [10:0]   PAIR_C     = 11'(PAY_PAIR);
  localparam logic [10:0]   TRIPLE_C   = 11'(PAY_TRIPLE);
  localparam logic [10:0]   MAX_C      = 11'(MAX_CREDITS);
  localparam logic [11:0]   START_BCD  = to_bcd(START_C);

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic            db_lvl_q, db_lvl_d, db_dly_q, db_dly_d, press_q, press_d;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [9:0]      credits_q, credits_d;
  logic [11:0]     bcd_q, bcd_d;
  logic [1:0]      result_q, result_d;
  logic            win_q, win_d;
  logic [3:0]      r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [10:0]     payout, sum;
  logic            eq12, eq13, eq23;

  always_ff @(posedge clock_in or posedge CLR) begin
    if (CLR) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_lvl_q  <= 1'b0;
      db_dly_q  <= 1'b0;
      press_q   <= 1'b0;
      db_cnt_q  <= '0;
      tmo_q     <= '0;
      credits_q <= START_C;
      bcd_q     <= START_BCD;
      result_q  <= 2'b00;
      win_q     <= 1'b0;
      r1_q      <= 4'd0;
      r2_q      <= 4'd0;
      r3_q      <= 4'd0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_lvl_q  <= db_lvl_d;
      db_dly_q  <= db_dly_d;
      press_q   <= press_d;
      db_cnt_q  <= db_cnt_d;
      tmo_q     <= tmo_d;
      credits_q <= credits_d;
      bcd_q     <= bcd_d;
      result_q  <= result_d;
      win_q     <= win_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      r3_q      <= r3_d;
    end
  end

  // Button conditioning: the count restarts whenever the synchronized level returns to the accepted one.
  always_comb begin
    sync1_d  = button;
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == db_lvl_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_lvl_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
    db_dly_d = db_lvl_q;
    press_d  = db_lvl_q & ~db_dly_q;
  end

  always_comb begin
    eq12   = (r1_q == r2_q);
    eq13   = (r1_q == r3_q);
    eq23   = (r2_q == r3_q);
    payout = (result_q == 2'b10) ? TRIPLE_C : (result_q == 2'b01) ? PAIR_C : 11'd0;
    sum    = {1'b0, credits_q} + payout;
  end

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    result_d  = result_q;
    win_d     = win_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    r3_d      = r3_q;
    tmo_d     = '0;
    bcd_d     = to_bcd(credits_q);
    case (state_q)
      S_IDLE:      if (press_q && (credits_q >= BET_C)) state_d = S_DEBIT;
      S_DEBIT: begin
        credits_d = credits_q - BET_C;
        result_d  = 2'b00;
        win_d     = 1'b0;
        state_d   = S_LAUNCH;
      end
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        tmo_d = tmo_q + TW'(1);
        if (reels_busy) begin
          state_d = S_WAIT_STOP;
        end else if (tmo_q == TMO_LAST) begin
          // Reels never moved: they were already on target, so their values are final.
          r1_d    = reel1;
          r2_d    = reel2;
          r3_d    = reel3;
          state_d = S_EVAL;
        end
      end
      S_WAIT_STOP: begin
        if (!reels_busy) begin
          r1_d    = reel1;
          r2_d    = reel2;
          r3_d    = reel3;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (eq12 && eq23)              result_d = 2'b10;
        else if (eq12 || eq13 || eq23) result_d = 2'b01;
        else                           result_d = 2'b00;
        win_d   = (eq12 || eq13 || eq23);
        state_d = S_PAY;
      end
      S_PAY: begin
        credits_d = (sum > MAX_C) ? MAX_C[9:0] : sum[9:0];
        state_d   = S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  assign spin_start  = (state_q == S_LAUNCH);
  assign credits_bcd = bcd_q;
  assign result      = result_q;
  assign win         = win_q;
  assign game_over   = (state_q == S_IDLE) && (credits_q < BET_C);

endmodule
